// File: rtl/fma_dot_seq.sv
// -----------------------------------------------------------------------------
// fma_dot_seq
//
// Sequencer around an unsigned multiply-accumulate step. One start command
// computes the dot product of a streamed vector of (a,b) operand pairs:
// every accepted beat performs acc <= a*b + acc in a widened accumulator,
// and the finished sum is offered on a valid/ready result port.
//
// Build option:
//   FMA_DOT_SEQ_BIAS_EN  when defined, adds input 'bias' (sampled with start).
//                        The accumulator then starts at bias instead of zero.
//
// Ports:
//   clk         in   1          clock, all state on rising edge
//   rst_n       in   1          asynchronous active-low reset
//   start       in   1          command strobe, only honoured in IDLE
//   len         in   LEN_WIDTH  number of (a,b) pairs, sampled with start
//   bias        in   WIDTH      initial accumulator value (BIAS_EN only)
//   busy        out  1          high in RUN and DONE
//   in_valid    in   1          operand pair valid
//   in_ready    out  1          pair accepted this cycle (RUN only)
//   in_a        in   WIDTH      multiplicand
//   in_b        in   WIDTH      multiplier
//   out_valid   out  1          result valid (DONE only)
//   out_ready   in   1          consumer takes the result
//   out_result  out  ACC_WIDTH  accumulator contents
// -----------------------------------------------------------------------------
module fma_dot_seq #(
    parameter int WIDTH     = 4,
    parameter int LEN_WIDTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [LEN_WIDTH-1:0]             len,
`ifdef FMA_DOT_SEQ_BIAS_EN
    input  logic [WIDTH-1:0]                 bias,
`endif
    output logic                             busy,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_a,
    input  logic [WIDTH-1:0]                 in_b,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [2*WIDTH+LEN_WIDTH-1:0]     out_result
);

    // Wide enough for (2**LEN_WIDTH-1) maximal products plus a maximal bias.
    localparam int ACC_WIDTH = 2*WIDTH + LEN_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic [ACC_WIDTH-1:0] acc_init;
    logic [ACC_WIDTH-1:0] product;

`ifdef FMA_DOT_SEQ_BIAS_EN
    assign acc_init = ACC_WIDTH'(bias);
`else
    assign acc_init = '0;
`endif

    // Operands are widened before multiplying so the product is never truncated.
    assign product = ACC_WIDTH'(in_a) * ACC_WIDTH'(in_b);

    // Handshake outputs decode the registered state only; in_ready never
    // depends on in_valid, so there is no combinational loop through the source.
    assign busy       = (state_q != ST_IDLE);
    assign in_ready   = (state_q == ST_RUN);
    assign out_valid  = (state_q == ST_DONE);
    assign out_result = acc_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_d     = state_q;
        acc_d       = acc_q;
        remaining_d = remaining_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d       = acc_init;
                    remaining_d = len;
                    state_d     = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    acc_d       = acc_q + product;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // start is deliberately not looked at here: a command arriving
                // with the result handshake waits for the next IDLE cycle.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            remaining_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the values present before this edge, independent of ordering.
            state_q     <= state_d;
            acc_q       <= acc_d;
            remaining_q <= remaining_d;
        end
    end

endmodule

// File: tb/tb_fma_dot_seq.sv
// -----------------------------------------------------------------------------
// tb_fma_dot_seq
//
// Directed bench for fma_dot_seq with hand-computed expected results.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_fma_dot_seq;

    localparam int WIDTH     = 4;
    localparam int LEN_WIDTH = 4;
    localparam int ACC_WIDTH = 2*WIDTH + LEN_WIDTH;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [LEN_WIDTH-1:0] len;
    logic [WIDTH-1:0]     bias;
    logic                 busy;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_result;

    int tests_run  = 0;
    int tests_fail = 0;

    logic [WIDTH-1:0] va [16];
    logic [WIDTH-1:0] vb [16];

    int beats;
    int cycles;
    int rdy_cycles;
    int exp_bias;

    fma_dot_seq #(.WIDTH(WIDTH), .LEN_WIDTH(LEN_WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
`ifdef FMA_DOT_SEQ_BIAS_EN
        .bias       (bias),
`endif
        .busy       (busy),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [LEN_WIDTH-1:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    // Feeds va/vb until out_valid rises or a cycle budget runs out.
    task automatic feed(input bit toggle, output int n_beats, output int n_cycles,
                        output int n_rdy);
        int idx;
        idx      = 0;
        n_beats  = 0;
        n_cycles = 0;
        n_rdy    = 0;
        while (!out_valid && n_cycles < 200) begin
            in_valid = toggle ? ((n_cycles % 2) == 0) : 1'b1;
            in_a     = va[idx % 16];
            in_b     = vb[idx % 16];
            if (in_ready) n_rdy++;
            if (in_valid && in_ready) begin
                n_beats++;
                idx++;
            end
            tick();
            n_cycles++;
        end
        in_valid = 1'b0;
        check("done_within_budget", out_valid, 1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        bias      = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
`ifdef FMA_DOT_SEQ_BIAS_EN
        exp_bias  = 7;
`else
        exp_bias  = 0;
`endif

        #12;
        check("rst_busy",      busy,       0);
        check("rst_in_ready",  in_ready,   0);
        check("rst_out_valid", out_valid,  0);
        check("rst_result",    out_result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: three beats back to back -> 6 + 20 + 225
        va[0] = 4'd2;  vb[0] = 4'd3;
        va[1] = 4'd4;  vb[1] = 4'd5;
        va[2] = 4'd15; vb[2] = 4'd15;
        start_cmd(4'd3);
        check("t1_busy",     busy,     1);
        check("t1_in_ready", in_ready, 1);
        feed(1'b0, beats, cycles, rdy_cycles);
        check("t1_beats",     beats,      3);
        check("t1_latency",   cycles,     3);
        check("t1_rdy_cyc",   rdy_cycles, 3);
        check("t1_in_ready0", in_ready,   0);
        check("t1_result",    out_result, 251);
        drain();
        check("t1_idle_busy", busy,       0);
        check("t1_idle_ov",   out_valid,  0);
        check("t1_held",      out_result, 251);

        // in_valid outside RUN is ignored
        in_valid = 1'b1;
        tick();
        check("idle_in_ready", in_ready,   0);
        check("idle_result",   out_result, 251);
        in_valid = 1'b0;

        // 2: fifteen maximal beats with in_valid toggling
        for (int i = 0; i < 16; i++) begin
            va[i] = 4'd15;
            vb[i] = 4'd15;
        end
        start_cmd(4'd15);
        feed(1'b1, beats, cycles, rdy_cycles);
        check("t2_beats",  beats,      15);
        check("t2_cycles", cycles,     29);
        check("t2_result", out_result, 3375);

        // 3: result held while consumer stalls; start ignored
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            len   = 4'd5;
            tick();
            check("t3_result", out_result, 3375);
            check("t3_busy",   busy,       1);
            check("t3_ovalid", out_valid,  1);
        end
        // handshake and start together: start must not be taken
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check("t3_hs_idle", busy,       0);
        check("t3_hs_res",  out_result, 3375);

        // 4: zero-length vector
        bias = 4'd7;
        start_cmd(4'd0);
        check("t4_ovalid",   out_valid,  1);
        check("t4_in_ready", in_ready,   0);
        check("t4_result",   out_result, exp_bias);
        drain();
        bias = 4'd0;

        // 5: reset in the middle of a vector
        va[0] = 4'd3; vb[0] = 4'd3;
        start_cmd(4'd4);
        in_valid = 1'b1;
        in_a = 4'd2; in_b = 4'd2;
        tick();
        tick();
        in_valid = 1'b0;
        check("t5_pre_busy", busy, 1);
        rst_n = 1'b0;
        #2;
        check("t5_busy",     busy,       0);
        check("t5_ovalid",   out_valid,  0);
        check("t5_in_ready", in_ready,   0);
        check("t5_result",   out_result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start_cmd(4'd1);
        feed(1'b0, beats, cycles, rdy_cycles);
        check("t5_beats",  beats,      1);
        check("t5_result", out_result, 9);
        drain();

`ifdef FMA_DOT_SEQ_BIAS_EN
        // 6: bias 15 + 225 + 1
        bias  = 4'd15;
        va[0] = 4'd15; vb[0] = 4'd15;
        va[1] = 4'd1;  vb[1] = 4'd1;
        start_cmd(4'd2);
        bias  = 4'd0;
        feed(1'b0, beats, cycles, rdy_cycles);
        check("t6_result", out_result, 241);
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
